multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports are listed clock and reset first.
REQ-002 clk  in  1  — rising-edge clock.
REQ-003 reset  in  1  — asynchronous, active-high; forces state FETCH.
REQ-004 opcode  in  6  — instruction[31:26] from the instruction register; stable from DECODE until the instruction completes.
REQ-005 funct  in  6  — instruction[5:0] from the instruction register.
REQ-006 zero  in  1  — ALU zero flag.
REQ-007 mem_ready  in  1  — memory has completed the current read or write this cycle.
REQ-008 alu_op  out  2  — 00 add, 01 subtract, 10 R-type (use funct); this is the consumer-side encoding of the ALU control decoder.
REQ-009 alu_src_a  out  1  — 0 selects PC, 1 selects register A.
REQ-010 alu_src_b  out  2  — 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
REQ-011 pc_src  out  2  — 00 ALU result, 01 ALUOut register, 10 jump target, 11 register rs.
REQ-012 pc_en  out  1 — PC load enable. ir_write, iord, mem_write, reg_dst, mem_to_reg, reg_write: each out, 1 bit, standard multicycle datapath meanings.
REQ-013 illegal_op  out  1 — one-cycle pulse on an unsupported opcode. state  out  4 — current state, for debug.

Function
REQ-014 The FSM SHALL be a registered Moore machine; outputs decode from state only, except ir_write, pc_en and the mem_ready waits defined below.
REQ-015 The states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JR.
REQ-016 Default values for every output not named in a state SHALL be 0.
REQ-017 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=mem_ready, pc_en=mem_ready. The FSM stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- 100011 or 101011 -> MEMADR.
- 000000 -> JR if funct=001000, otherwise EXECUTE.
- 000100 or 000101 -> BRANCH.
- 001000 -> ADDIEX.
- 000010 -> JUMP.
- Any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD if opcode=100011, else MEMWR.
REQ-020 MEMRD: iord=1. The FSM waits for mem_ready, then goes to MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
REQ-021 MEMWR: iord=1, mem_write=1, held until the cycle in which mem_ready=1, then FETCH; exactly one write is accepted.
REQ-022 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_en = zero for opcode 000100, ~zero for opcode 000101. Then FETCH.
REQ-024 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
REQ-025 JUMP: pc_src=10, pc_en=1, then FETCH. JR: pc_src=11, pc_en=1, then FETCH.
REQ-026 Instruction latency SHALL be as follows, with zero memory wait:
- lw: 5 cycles.
- R-type, addi, sw: 4 cycles.
- beq, bne, j, jr: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
REQ-027 reg_write, mem_write and pc_en SHALL never be asserted in the same cycle as each other, except where pc_en is asserted together with ir_write in FETCH.
REQ-028 Unreachable state encodings SHALL return to FETCH on the next clock with all write enables 0.

Reset
REQ-029 While reset=1, the state SHALL be FETCH and pc_en, ir_write, mem_write, reg_write and illegal_op SHALL be 0, regardless of mem_ready.
REQ-030 When reset is asserted mid-instruction (including a MEMWR wait), the FSM SHALL abandon the instruction immediately, with no further write enables.

Structure
REQ-031 The package mips_ctrl_pkg SHALL hold the following, shared with the ALU control decoder:
- state encodings;
- opcode and funct constants;
- alu_op encodings;
- alu_src_b and pc_src encodings.
REQ-032 The block SHALL be flat, with no sub-module. The ALU control decoder is instantiated beside it at datapath level, not inside it.

Verification
REQ-033 lw sequence: with mem_ready=1, opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-034 Fetch wait: mem_ready=0 for 3 cycles in FETCH -> ir_write=0 and pc_en=0 for 3 cycles, then both 1 for one cycle.
REQ-035 Branches:
- beq (000100) with zero=1 -> pc_en=1 and pc_src=01 in BRANCH.
- bne (000101) with zero=1 -> pc_en=0.
REQ-036 R-type: funct=100000 -> alu_op=10 in EXECUTE and reg_dst=1 in ALUWB. funct=001000 -> JR state with pc_src=11 and pc_en=1.
REQ-037 Illegal opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH.
REQ-038 Reset during MEMWR with mem_ready=0 -> mem_write drops the same cycle and state=FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle control FSM and the ALU control decoder.
//   Holds state encodings, opcode/funct constants, alu_op, alu_src_b and pc_src encodings,
//   plus the DECODE dispatch helper.
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // Successor of DECODE; S_FETCH means the opcode is unsupported.
    function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_LW || opcode == OP_SW)   ? S_MEMADR :
               (opcode == OP_RTYPE)                   ? ((funct == FN_JR) ? S_JR : S_EXECUTE) :
               (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
               (opcode == OP_ADDI)                    ? S_ADDIEX :
               (opcode == OP_J)                       ? S_JUMP : S_FETCH;
    endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS datapath.
//   in : clk, reset (async, active-high), opcode, funct, zero, mem_ready
//   out: alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, iord, mem_write,
//        reg_dst, mem_to_reg, reg_write, illegal_op, state (debug)
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);
    state_t cur, nxt, dec;

    assign dec   = decode_next(opcode, funct);
    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt        = S_FETCH;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                nxt       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                nxt        = dec;
                illegal_op = (dec == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                nxt  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                nxt       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_en     = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            S_JR: begin
                pc_src = PC_RS;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence write enables combinationally, even while FETCH sees mem_ready.
        if (reset) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench for multicycle_control.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_b, pc_src;
    logic       alu_src_a, pc_en, ir_write, iord, mem_write, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state;
    logic [18:0] obs;

    typedef struct {
        logic        mr;
        logic [18:0] e;
        string       tag;
    } item_t;

    item_t sb[$];
    int passed = 0;
    int total = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write,
                  iord, mem_write, reg_dst, mem_to_reg, reg_write, illegal_op};

    // Expected output vector for a state, written from the control table.
    function automatic logic [18:0] ev(input state_t s, input logic pe, input logic iw, input logic il);
        logic [1:0] op = 2'b00;
        logic [1:0] b = 2'b00;
        logic [1:0] ps = 2'b00;
        logic a = 1'b0, io = 1'b0, mw = 1'b0, rd = 1'b0, mtr = 1'b0, rw = 1'b0;
        case (s)
            S_FETCH:   b = 2'b01;
            S_DECODE:  b = 2'b11;
            S_MEMADR:  begin a = 1'b1; b = 2'b10; end
            S_MEMRD:   io = 1'b1;
            S_MEMWB:   begin mtr = 1'b1; rw = 1'b1; end
            S_MEMWR:   begin io = 1'b1; mw = 1'b1; end
            S_EXECUTE: begin a = 1'b1; op = 2'b10; end
            S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
            S_BRANCH:  begin a = 1'b1; op = 2'b01; ps = 2'b01; end
            S_ADDIEX:  begin a = 1'b1; b = 2'b10; end
            S_ADDIWB:  rw = 1'b1;
            S_JUMP:    ps = 2'b10;
            S_JR:      ps = 2'b11;
            default:   ;
        endcase
        return {4'(s), op, a, b, ps, pe, iw, io, mw, rd, mtr, rw, il};
    endfunction

    task automatic push(input state_t s, input logic mr, input logic pe, input logic iw,
                        input logic il, input string tag);
        item_t it;
        it.mr  = mr;
        it.e   = ev(s, pe, iw, il);
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    task automatic fetch(input string tag);
        push(S_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, tag);
    endtask

    // Pops one scoreboard entry per clock: drive its mem_ready, sample mid-cycle, compare.
    task automatic drain();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr;
            #2;
            check(it.tag, obs, it.e);
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        mem_ready = 1'b1;
        #2;
        check("reset_hold", obs, ev(S_FETCH, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        check("reset_hold_edge", obs, ev(S_FETCH, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;

        set_instr(OP_LW, 6'd0, 1'b0);
        fetch("lw_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "lw_decode");
        push(S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, "lw_memadr");
        push(S_MEMRD,  1'b1, 1'b0, 1'b0, 1'b0, "lw_memrd");
        push(S_MEMWB,  1'b1, 1'b0, 1'b0, 1'b0, "lw_memwb");
        drain();

        set_instr(OP_J, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) push(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, "fetch_wait");
        fetch("fetch_done");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "j_decode");
        push(S_JUMP,   1'b1, 1'b1, 1'b0, 1'b0, "j_jump");
        drain();

        set_instr(OP_BEQ, 6'd0, 1'b1);
        fetch("beq1_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "beq1_decode");
        push(S_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0, "beq_taken");
        drain();
        set_instr(OP_BNE, 6'd0, 1'b1);
        fetch("bne1_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "bne1_decode");
        push(S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not_taken");
        drain();
        set_instr(OP_BEQ, 6'd0, 1'b0);
        fetch("beq0_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "beq0_decode");
        push(S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, "beq_not_taken");
        drain();
        set_instr(OP_BNE, 6'd0, 1'b0);
        fetch("bne0_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "bne0_decode");
        push(S_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0, "bne_taken");
        drain();

        set_instr(OP_RTYPE, FN_ADD, 1'b0);
        fetch("add_fetch");
        push(S_DECODE,  1'b1, 1'b0, 1'b0, 1'b0, "add_decode");
        push(S_EXECUTE, 1'b1, 1'b0, 1'b0, 1'b0, "add_execute");
        push(S_ALUWB,   1'b1, 1'b0, 1'b0, 1'b0, "add_aluwb");
        drain();

        set_instr(OP_RTYPE, FN_JR, 1'b0);
        fetch("jr_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "jr_decode");
        push(S_JR,     1'b1, 1'b1, 1'b0, 1'b0, "jr_jr");
        drain();

        set_instr(OP_ADDI, 6'd0, 1'b0);
        fetch("addi_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "addi_decode");
        push(S_ADDIEX, 1'b1, 1'b0, 1'b0, 1'b0, "addi_ex");
        push(S_ADDIWB, 1'b1, 1'b0, 1'b0, 1'b0, "addi_wb");
        drain();

        set_instr(6'b111111, 6'd0, 1'b0);
        fetch("ill_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b1, "ill_decode");
        drain();

        set_instr(OP_LW, 6'd0, 1'b0);
        fetch("lw2_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "lw2_decode");
        push(S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, "lw2_memadr");
        push(S_MEMRD,  1'b0, 1'b0, 1'b0, 1'b0, "lw2_memrd_wait");
        push(S_MEMRD,  1'b0, 1'b0, 1'b0, 1'b0, "lw2_memrd_wait");
        push(S_MEMRD,  1'b1, 1'b0, 1'b0, 1'b0, "lw2_memrd");
        push(S_MEMWB,  1'b1, 1'b0, 1'b0, 1'b0, "lw2_memwb");
        drain();

        set_instr(OP_SW, 6'd0, 1'b0);
        fetch("sw_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "sw_decode");
        push(S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, "sw_memadr");
        push(S_MEMWR,  1'b0, 1'b0, 1'b0, 1'b0, "sw_memwr_wait");
        push(S_MEMWR,  1'b1, 1'b0, 1'b0, 1'b0, "sw_memwr");
        fetch("sw_next_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "sw2_decode");
        push(S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, "sw2_memadr");
        push(S_MEMWR,  1'b0, 1'b0, 1'b0, 1'b0, "sw2_memwr_wait");
        drain();

        mem_ready = 1'b0;
        #1;
        check("sw2_still_writing", obs, ev(S_MEMWR, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        check("rst_in_memwr", obs, ev(S_FETCH, 1'b0, 1'b0, 1'b0));
        mem_ready = 1'b1;
        #1;
        check("rst_mem_ready", obs, ev(S_FETCH, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        set_instr(OP_J, 6'd0, 1'b0);
        fetch("post_rst_fetch");
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_decode");
        push(S_JUMP,   1'b1, 1'b1, 1'b0, 1'b0, "post_rst_jump");
        fetch("final_fetch");
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
